// File: rtl/aes_ahb_pkg.sv
// aes_ahb_pkg: AHB-Lite encodings, master states and the default AES slave address map.
package aes_ahb_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3} htrans_t;
    typedef enum logic [3:0] {S_IDLE, S_MODE, S_GAP1, S_KEY, S_GAP2, S_WDATA, S_GAP3, S_RDATA, S_FIN} state_t;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR = 3'd1;
    localparam logic [1:0] HR_OKAY = 2'd0;
    localparam logic [1:0] HR_ERROR = 2'd1;
    localparam logic [31:0] DEF_MODE_ENC_ADDR = 32'h04;
    localparam logic [31:0] DEF_MODE_DEC_ADDR = 32'h08;
    localparam logic [31:0] DEF_KEY_BASE = 32'h10;
    localparam logic [31:0] DEF_WDATA_BASE = 32'h40;
    localparam logic [31:0] DEF_RDATA_BASE = 32'h80;
    // Beat 4b+w is the most-significant-first word w of block b, i.e. packed word 4b+3-w
    function automatic logic [3:0] word_idx(input logic [3:0] beat);
        return {beat[3:2], ~beat[1:0]};
    endfunction
endpackage

// File: rtl/aes_ahb_master_beat_counter.sv
// ahb_beat_counter: burst beat index that advances only on accepted address phases.
module ahb_beat_counter
    import aes_ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       clear,
    input  logic       enable,
    input  logic       hready,
    input  logic [3:0] beats_m1,
    output logic [3:0] count,
    output logic       last
);
    logic [3:0] count_q, count_d;
    always_comb count_d = clear ? 4'd0 : (enable && hready) ? count_q + 4'd1 : count_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) count_q <= 4'd0;
        else count_q <= count_d;
    end
    assign count = count_q;
    assign last = count_q == beats_m1;
endmodule

// File: rtl/aes_ahb_master.sv
// aes_ahb_master: AHB-Lite master running one AES job (mode, key, 4 blocks in, 16 words out)
// against the AES_toplevel slave.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter logic [31:0] MODE_ENC_ADDR = DEF_MODE_ENC_ADDR,
    parameter logic [31:0] MODE_DEC_ADDR = DEF_MODE_DEC_ADDR,
    parameter logic [31:0] KEY_BASE = DEF_KEY_BASE,
    parameter logic [31:0] WDATA_BASE = DEF_WDATA_BASE,
    parameter logic [31:0] RDATA_BASE = DEF_RDATA_BASE
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              decrypt,
    input  logic [127:0]      key,
    input  logic [3:0][127:0] in_data,
    output logic [15:0][31:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              HSELx,
    output logic [31:0]       HADDR,
    output logic [31:0]       HWDATA,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);
    state_t state_q, state_d;
    htrans_t htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, base;
    logic [2:0] hburst_q, hburst_d;
    logic hsel_q, hsel_d, hwrite_q, hwrite_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic rd_pend_q, rd_pend_d, last, in_burst;
    logic [3:0] rd_idx_q, rd_idx_d, beat;
    logic [3:0][31:0] key_q, key_d;
    logic [15:0][31:0] wd_q, wd_d, out_q, out_d;

    assign in_burst = state_q inside {S_KEY, S_WDATA, S_RDATA};
    assign base = (state_q inside {S_GAP1, S_KEY}) ? KEY_BASE :
                  (state_q inside {S_GAP2, S_WDATA}) ? WDATA_BASE : RDATA_BASE;

    ahb_beat_counter u_beat (
        .HCLK(HCLK), .HRESETn(HRESETn), .clear(!in_burst), .enable(in_burst), .hready(HREADY),
        .beats_m1(state_q == S_KEY ? 4'd3 : 4'd15), .count(beat), .last(last)
    );

    always_comb begin
        state_d = state_q;
        htrans_d = htrans_q;
        haddr_d = haddr_q;
        hwdata_d = hwdata_q;
        hburst_d = hburst_q;
        hsel_d = hsel_q;
        hwrite_d = hwrite_q;
        busy_d = busy_q;
        done_d = 1'b0;
        error_d = error_q;
        rd_pend_d = rd_pend_q;
        rd_idx_d = rd_idx_q;
        key_d = key_q;
        wd_d = wd_q;
        out_d = out_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_MODE;
                htrans_d = HT_NONSEQ;
                haddr_d = decrypt ? MODE_DEC_ADDR : MODE_ENC_ADDR;
                hburst_d = HB_SINGLE;
                hsel_d = 1'b1;
                hwrite_d = 1'b1;
                busy_d = 1'b1;
                error_d = 1'b0;
                key_d = key;
                wd_d = in_data;
            end
        end else if (!HREADY) begin
            // First cycle of a two-cycle ERROR response: cancel the pending address phase
            if (HRESP == HR_ERROR) begin
                state_d = S_FIN;
                htrans_d = HT_IDLE;
                hsel_d = 1'b0;
                error_d = 1'b1;
                rd_pend_d = 1'b0;
            end
        end else begin
            if (rd_pend_q) out_d[rd_idx_q] = HRDATA;
            rd_pend_d = state_q == S_RDATA;
            rd_idx_d = beat;
            case (state_q)
                S_MODE: begin
                    state_d = S_GAP1;
                    htrans_d = HT_IDLE;
                    hsel_d = 1'b0;
                    hwdata_d = '0;
                end
                S_GAP1, S_GAP2, S_GAP3: begin
                    state_d = state_q == S_GAP1 ? S_KEY : state_q == S_GAP2 ? S_WDATA : S_RDATA;
                    htrans_d = HT_NONSEQ;
                    haddr_d = base;
                    hburst_d = HB_INCR;
                    hsel_d = 1'b1;
                    hwrite_d = state_q != S_GAP3;
                end
                S_KEY, S_WDATA, S_RDATA: begin
                    hwdata_d = state_q == S_KEY ? key_q[~beat[1:0]] :
                               state_q == S_WDATA ? wd_q[word_idx(beat)] : hwdata_q;
                    htrans_d = last ? HT_IDLE : HT_SEQ;
                    hsel_d = !last;
                    haddr_d = last ? haddr_q : base + {26'd0, beat + 4'd1, 2'b00};
                    if (last) state_d = state_q == S_KEY ? S_GAP2 : state_q == S_WDATA ? S_GAP3 : S_FIN;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            htrans_q <= HT_IDLE;
            haddr_q <= '0;
            hwdata_q <= '0;
            hburst_q <= '0;
            hsel_q <= 1'b0;
            hwrite_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q <= '0;
            key_q <= '0;
            wd_q <= '0;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            htrans_q <= htrans_d;
            haddr_q <= haddr_d;
            hwdata_q <= hwdata_d;
            hburst_q <= hburst_d;
            hsel_q <= hsel_d;
            hwrite_q <= hwrite_d;
            busy_q <= busy_d;
            done_q <= done_d;
            error_q <= error_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q <= rd_idx_d;
            key_q <= key_d;
            wd_q <= wd_d;
            out_q <= out_d;
        end
    end

    assign HSELx = hsel_q;
    assign HADDR = haddr_q;
    assign HWDATA = hwdata_q;
    assign HBURST = hburst_q;
    assign HPROT = 4'd0;
    assign HSIZE = 3'd2;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign busy = busy_q;
    assign done = done_q;
    assign error = error_q;
    assign out_data = out_q;
endmodule

// File: tb/tb_aes_ahb_master.sv
// tb_aes_ahb_master: job table run against a behavioral AHB slave; every bus transfer is
// checked against a scoreboard of transfers queued when the job is started.
module tb_aes_ahb_master;
    import aes_ahb_pkg::*;

    logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0, decrypt = 1'b0;
    logic [127:0] key = '0;
    logic [3:0][127:0] in_data = '0;
    logic [15:0][31:0] out_data;
    logic busy, done, error, HSELx, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0] HBURST, HSIZE;
    logic [3:0] HPROT;
    logic [1:0] HTRANS, HRESP;
    logic [67:0] cur;
    int checks = 0, errors = 0;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } xfer_t;
    typedef struct { logic dec; logic rnd; logic stall; logic err; logic extra; int lat; logic exp_err; } job_t;
    xfer_t sb[$];
    job_t jobs[6];
    logic sb_off = 1'b0, stall_en = 1'b0, err_en = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0][31:0] exp_out = '0;

    always #5 HCLK = ~HCLK;

    aes_ahb_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .decrypt(decrypt), .key(key),
        .in_data(in_data), .out_data(out_data), .busy(busy), .done(done), .error(error),
        .HSELx(HSELx), .HADDR(HADDR), .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    assign cur = {HSELx, HTRANS, HWRITE, HADDR, HWDATA};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    task automatic log_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        xfer_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected: got w=%0d addr %0h want no transfer", w, a);
        end else begin
            e = sb.pop_front();
            chk("xfer_addr", {w, a}, {e.w, e.a});
            if (e.w) chk("xfer_wdata", d, e.d);
        end
    endtask

    // Behavioral slave: optional wait states on 0x54 / 0x80, optional ERROR on 0x18
    logic dp_v, dp_w, err_ph;
    logic [31:0] dp_a;
    int wait_n;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_v = 1'b0;
            err_ph = 1'b0;
            wait_n = 0;
            HREADY <= 1'b1;
            HRESP <= HR_OKAY;
            HRDATA <= '0;
        end else if (!HREADY) begin
            if (err_ph) begin
                err_ph = 1'b0;
                HREADY <= 1'b1;
            end else begin
                wait_n--;
                if (wait_n == 0) begin
                    HREADY <= 1'b1;
                    HRDATA <= rd_word(dp_a);
                end
            end
        end else begin
            if (dp_v && !sb_off) log_xfer(dp_w, dp_a, HWDATA);
            HRESP <= HR_OKAY;
            dp_v = HSELx && HTRANS[1];
            dp_w = HWRITE;
            dp_a = HADDR;
            wait_n = (!dp_v || !stall_en) ? 0 : HADDR == 32'h54 ? 2 : HADDR == 32'h80 ? 1 : 0;
            if (dp_v && err_en && HADDR == 32'h18) begin
                dp_v = 1'b0;
                err_ph = 1'b1;
                HREADY <= 1'b0;
                HRESP <= HR_ERROR;
            end else if (wait_n != 0) begin
                HREADY <= 1'b0;
                HRDATA <= 32'hDEADBEEF;
            end else HRDATA <= rd_word(HADDR);
        end
    end

    // Mid-cycle monitor: stalls must freeze the bus, an ERROR must cancel the next address
    logic hr_p = 1'b1;
    logic [1:0] hresp_p = HR_OKAY;
    logic [67:0] bus_p = '0;
    always @(negedge HCLK) begin
        if (HRESETn && !hr_p && hresp_p == HR_OKAY) chk("stall_hold", cur, bus_p);
        if (HRESETn && !hr_p && hresp_p == HR_ERROR) chk("err_abort", {HSELx, HTRANS, error}, 4'b0001);
        hr_p = HREADY;
        hresp_p = HRESP;
        bus_p = cur;
    end

    task automatic chk_reset();
        chk("rst_bus", {HSELx, HTRANS, HWRITE, HBURST, HADDR, HWDATA}, '0);
        chk("rst_const", {HPROT, HSIZE}, {4'd0, 3'd2});
        chk("rst_status", {busy, done, error}, 3'b000);
        for (int i = 0; i < 16; i++) chk("rst_out", out_data[i], 32'd0);
    endtask

    task automatic run_job(input job_t j);
        logic [31:0] w;
        logic [127:0] blk;
        int n;
        decrypt = j.dec;
        stall_en = j.stall;
        err_en = j.err;
        seed = $urandom;
        for (int b = 0; b < 4; b++)
            in_data[b] = j.rnd ? {$urandom, $urandom, $urandom, $urandom} : "1234567890123456";
        key = j.rnd ? {$urandom, $urandom, $urandom, $urandom} : "ZXCVBNMASDFGHJKL";
        sb.push_back('{1'b1, j.dec ? 32'h08 : 32'h04, 32'd0});
        for (int i = 0; i < (j.err ? 2 : 4); i++) begin
            w = key[127-32*i -: 32];
            sb.push_back('{1'b1, 32'h10 + 32'(4 * i), w});
        end
        if (!j.err) begin
            for (int i = 0; i < 16; i++) begin
                blk = in_data[i/4];
                w = blk[127-32*(i%4) -: 32];
                sb.push_back('{1'b1, 32'h40 + 32'(4 * i), w});
            end
            for (int i = 0; i < 16; i++) begin
                sb.push_back('{1'b0, 32'h80 + 32'(4 * i), 32'd0});
                exp_out[i] = rd_word(32'h80 + 32'(4 * i));
            end
        end
        @(negedge HCLK) start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        n = 0;
        while (!done && n < 300) begin
            @(posedge HCLK);
            #1 n++;
            if (j.extra) start = (n == 15);
        end
        start = 1'b0;
        chk("done_latency", n, j.lat);
        chk("busy_at_done", {busy, done}, 2'b01);
        @(posedge HCLK);
        #1 chk("done_pulse", done, 1'b0);
        repeat (20) @(posedge HCLK);
        #1 chk("sb_drained", sb.size(), 0);
        sb.delete();
        chk("error_flag", {busy, error}, {1'b0, j.exp_err});
        for (int i = 0; i < 16; i++) chk("out_data", out_data[i], exp_out[i]);
    endtask

    initial begin
        jobs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 41, 1'b0};
        jobs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 41, 1'b0};
        jobs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 44, 1'b0};
        jobs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7, 1'b1};
        jobs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 44, 1'b0};
        jobs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 41, 1'b0};
        repeat (3) @(posedge HCLK);
        #1 chk_reset();
        @(negedge HCLK) HRESETn = 1'b1;
        for (int j = 0; j < 6; j++) run_job(jobs[j]);
        sb_off = 1'b1;
        @(negedge HCLK) start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 chk("midkey_pre", {HTRANS, HADDR}, {2'd3, 32'h14});
        #1 HRESETn = 1'b0;
        #1 chk_reset();
        exp_out = '0;
        @(negedge HCLK) HRESETn = 1'b1;
        sb_off = 1'b0;
        run_job(jobs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_ahb_master.md
# aes_ahb_master

Synthesizable AHB-Lite master that performs one complete AES job against the `AES_toplevel` slave. On `start` it:

- selects encrypt or decrypt,
- loads a 128-bit key,
- writes four 128-bit blocks into the input FIFO region,
- reads back the sixteen result words.

It sits between a local command interface (CPU/DMA side) and the AHB-Lite bus that feeds `AES_toplevel`, replacing bench-driven bus stimulus in system-level builds.

## Interface

**Parameters**
- `MODE_ENC_ADDR`, 32'h04: write target that selects encrypt.
- `MODE_DEC_ADDR`, 32'h08: write target that selects decrypt.
- `KEY_BASE`, 32'h10: base of the 4-word key region.
- `WDATA_BASE`, 32'h40: base of the 16-word input region.
- `RDATA_BASE`, 32'h80: base of the 16-word output region.

**Ports**
- `HCLK` in 1: clock. Single clock domain.
- `HRESETn` in 1: reset. Asynchronous, active-low.
- `start` in 1: begin a job. Sampled only in IDLE.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt. Captured with `start`.
- `key` in 128: AES key. `[127:96]` is sent first. Captured with `start`.
- `in_data` in [3:0][127:0]: four blocks. Block 0, bits `[127:96]` are sent first. Captured with `start`.
- `out_data` out [15:0][31:0]: read-back words. Word `j` comes from `RDATA_BASE+4j`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when a job completes or aborts.
- `error` out 1: set on an HRESP ERROR; held until the next `start`.
- `HSELx` out 1: high during NONSEQ/SEQ address phases only.
- `HADDR` out 32: address.
- `HWDATA` out 32: write data, driven in the data phase.
- `HBURST` out 3: SINGLE for the mode write, INCR for the key, write and read bursts.
- `HPROT` out 4: constant 0.
- `HSIZE` out 3: constant 2 (word).
- `HTRANS` out 2: IDLE=0, NONSEQ=2, SEQ=3.
- `HWRITE` out 1: write indicator.
- `HRDATA` in 32: read data.
- `HREADY` in 1: transfer ready.
- `HRESP` in 2: 0 = OKAY, 1 = ERROR.

## Operation

**States:** IDLE → MODE → GAP1 → KEY → GAP2 → WDATA → GAP3 → RDATA → FIN → IDLE.

- **IDLE**
  - Bus outputs are IDLE and `HSELx=0`.
  - `start=1` captures `decrypt`, `key`, `in_data` and clears `error`.
- **MODE**
  - One SINGLE NONSEQ write to `MODE_DEC_ADDR` if `decrypt`, else to `MODE_ENC_ADDR`.
  - Data phase drives `HWDATA=0`.
- **GAPn**
  - One IDLE address cycle, overlapping the previous burst's final data phase.
- **KEY**
  - INCR write of 4 beats to `KEY_BASE` .. `KEY_BASE+0xC`.
  - First beat is NONSEQ, the rest are SEQ.
  - Beat `i` data is `key[127-32i -: 32]`.
- **WDATA**
  - INCR write of 16 beats to `WDATA_BASE` .. `+0x3C`.
  - Beat `4b+w` data is `in_data[b][127-32w -: 32]`.
- **RDATA**
  - INCR read of 16 beats, with `HWRITE=0`.
  - `HRDATA` is captured into `out_data[j]` at the end of data phase `j` when `HREADY=1`.
- **FIN**
  - Final read data phase, with IDLE on the address bus.
  - Then pulse `done`, drop `busy` and return to IDLE.

**Other rules**
- A 4-bit beat counter indexes addresses and data words. `HADDR = base + 4*beat`; there is no wrap, and the counter resets at each burst start.
- `start` while `busy` is ignored.
- `out_data` holds its value until overwritten by the next job's reads.
- **HRESP ERROR (two-cycle response)**
  - In the first cycle (`HREADY=0`), drive `HTRANS=IDLE` and `HSELx=0` on the next edge.
  - Set `error`, skip to FIN, then pulse `done`.
  - `out_data` words not yet read keep their old values.
- **Reset mid-job:** all state returns immediately to IDLE, and every output returns to its reset value.

## Timing

- **Reset values**
  - `HSELx=0`, `HADDR=0`, `HWDATA=0`, `HBURST=0`, `HTRANS=IDLE`, `HWRITE=0`.
  - `HPROT=0`, `HSIZE=2`.
  - `busy=0`, `done=0`, `error=0`, `out_data=0`.
- All bus outputs are registered.
- The address phase of beat `n+1` coincides with the data phase of beat `n`.
- **`HREADY=0`:** hold `HADDR`/`HTRANS`/`HWRITE`/`HSELx` and `HWDATA` unchanged, do not advance the beat counter, and do not capture `HRDATA`.
- **Zero-wait-state latency**
  - `start` is sampled at edge E0.
  - MODE address is driven after E0.
  - `done` goes high after edge E0+41.
  - Each `HREADY=0` cycle adds exactly one cycle.
- `done` is high for exactly one cycle. `busy` falls on the same edge that `done` rises.

## Structure

- **Package `aes_ahb_pkg`**
  - `htrans_t` enum (IDLE, BUSY, NONSEQ, SEQ).
  - HBURST constants SINGLE=0, INCR=1.
  - HRESP constants OKAY=0, ERROR=1.
  - Master state enum.
  - Default address-map constants.
- **Sub-module `ahb_beat_counter`:** 4-bit counter with `clear`, `enable` (gated by `HREADY`) and a `last` flag driven by a `beats-1` input.

## Test plan

- **Reset:** assert `HRESETn=0` mid-KEY burst → all outputs at reset values; `HTRANS=IDLE` within the asynchronous delay.
- **Encrypt job, zero wait:** `key="ZXCVBNMASDFGHJKL"`, four blocks `"1234567890123456"`, behavioral slave.
  - The slave log shows a write to 0x04, key words at 0x10–0x1C, and 16 writes at 0x40–0x7C.
  - Reads at 0x80–0xBC; `out_data` equals the slave's returned words.
  - `done` pulses after E0+41.
- **Decrypt job:** `decrypt=1` → mode write goes to 0x08; the rest of the sequence is identical.
- **Wait states:** slave inserts `HREADY=0` for 2 cycles on WDATA beat 5 and for 1 cycle on RDATA beat 0.
  - Address, data and control are held stable during the stall.
  - `done` is delayed by exactly 3 cycles; `out_data` is still correct.
- **Error:** slave returns two-cycle ERROR on KEY beat 2 → `HTRANS=IDLE` next cycle, `error=1`, `done` pulses, no WDATA/RDATA transfers occur.
- **Busy protection:** second `start` pulsed during WDATA → ignored; exactly one job's transfers appear on the bus.
